// File: rtl/crtc_timing.sv
// crtc_timing: CRTC-style video timing generator producing sync, active flags, MA and RA.
// Optional hardware cursor is enabled by defining CRTC_TIMING_CURSOR_EN.
module crtc_timing #(
    parameter int PIXEL_BITS = 3,
    parameter int H_BITS     = 8,
    parameter int V_BITS     = 7,
    parameter int RA_BITS    = 5,
    parameter int SYNC_BITS  = 4,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    input  logic [H_BITS-1:0]     h_char_total,
    input  logic [H_BITS-1:0]     h_char_displayed,
    input  logic [H_BITS-1:0]     h_sync_pos,
    input  logic [SYNC_BITS-1:0]  h_sync_width,
    input  logic [V_BITS-1:0]     v_char_total,
    input  logic [V_BITS-1:0]     v_char_displayed,
    input  logic [V_BITS-1:0]     v_sync_pos,
    input  logic [SYNC_BITS-1:0]  v_sync_width,
    input  logic [RA_BITS-1:0]    v_char_height,
    input  logic [RA_BITS-1:0]    v_adjust,
    input  logic [ADDR_WIDTH-1:0] start_addr,
`ifdef CRTC_TIMING_CURSOR_EN
    input  logic [ADDR_WIDTH-1:0] cursor_addr,
    input  logic [RA_BITS-1:0]    cursor_start,
    input  logic [RA_BITS-1:0]    cursor_end,
    input  logic                  cursor_blink,
    output logic                  cursor,
`endif
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [RA_BITS-1:0]    ra_out,
    output logic                  char_strobe,
    output logic                  h_sync,
    output logic                  v_sync,
    output logic                  h_active,
    output logic                  v_active,
    output logic                  frame_start
);

    typedef enum logic {ROWS, ADJUST} state_t;

    typedef struct packed {
        logic [H_BITS-1:0]    h_total;
        logic [H_BITS-1:0]    h_disp;
        logic [H_BITS-1:0]    h_spos;
        logic [SYNC_BITS-1:0] h_swid;
        logic [V_BITS-1:0]    v_total;
        logic [V_BITS-1:0]    v_disp;
        logic [V_BITS-1:0]    v_spos;
        logic [SYNC_BITS-1:0] v_swid;
        logic [RA_BITS-1:0]   v_height;
        logic [RA_BITS-1:0]   v_adjust;
    } cfg_t;

    state_t                state_q, state_d;
    cfg_t                  cfg_q, cfg_d, cfg_in;
    logic                  started_q;
    logic [PIXEL_BITS-1:0] pix_q, pix_d;
    logic [H_BITS-1:0]     hc_q, hc_d;
    logic [RA_BITS-1:0]    ra_q, ra_d;
    logic [V_BITS-1:0]     vc_q, vc_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [SYNC_BITS-1:0]  hs_cnt_q, hs_cnt_d;
    logic [SYNC_BITS-1:0]  vs_cnt_q, vs_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  strobe_q, strobe_d;
    logic                  hs_q, hs_d, vs_q, vs_d;
    logic                  ha_q, ha_d, va_q, va_d;
    logic                  fs_q, fs_d;
    logic                  frame_wrap;
    logic                  pix_wrap, line_end;

    assign cfg_in = {h_char_total, h_char_displayed, h_sync_pos, h_sync_width,
                     v_char_total, v_char_displayed, v_sync_pos, v_sync_width,
                     v_char_height, v_adjust};

    assign pix_wrap = (pix_q == '1);
    assign line_end = pix_wrap && (hc_q == cfg_q.h_total);

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        pix_d      = pix_q + PIXEL_BITS'(1);
        hc_d       = hc_q;
        ra_d       = ra_q;
        vc_d       = vc_q;
        row_base_d = row_base_q;
        frame_wrap = 1'b0;

        if (line_end) begin
            hc_d = '0;
            ra_d = ra_q + RA_BITS'(1);
            if (state_q == ROWS && ra_q == cfg_q.v_height) begin
                ra_d = '0;
                if (vc_q != cfg_q.v_total) begin
                    vc_d       = vc_q + V_BITS'(1);
                    row_base_d = row_base_q + ADDR_WIDTH'(cfg_q.h_disp);
                end else if (cfg_q.v_adjust != '0) begin
                    state_d = ADJUST;
                end else begin
                    frame_wrap = 1'b1;
                end
            end else if (state_q == ADJUST && ra_q == cfg_q.v_adjust - RA_BITS'(1)) begin
                frame_wrap = 1'b1;
            end
        end else if (pix_wrap) begin
            hc_d = hc_q + H_BITS'(1);
        end

        // The first clock after reset release is itself a frame start.
        fs_d = frame_wrap || !started_q;
        if (fs_d) begin
            state_d    = ROWS;
            cfg_d      = cfg_in;
            pix_d      = '0;
            hc_d       = '0;
            ra_d       = '0;
            vc_d       = '0;
            row_base_d = start_addr;
        end

        // Sync pulses run on their own down-counters so they can span line/frame wraps.
        hs_cnt_d = hs_cnt_q;
        if (pix_wrap || fs_d) begin
            if (hc_d == cfg_d.h_spos)
                hs_cnt_d = cfg_d.h_swid;
            else if (hs_cnt_q != '0)
                hs_cnt_d = hs_cnt_q - SYNC_BITS'(1);
        end

        vs_cnt_d = vs_cnt_q;
        if (line_end || fs_d) begin
            if (state_d == ROWS && vc_d == cfg_d.v_spos && ra_d == '0)
                vs_cnt_d = cfg_d.v_swid;
            else if (vs_cnt_q != '0)
                vs_cnt_d = vs_cnt_q - SYNC_BITS'(1);
        end

        addr_d   = row_base_d + ADDR_WIDTH'(hc_d);
        strobe_d = (pix_d == '0);
        hs_d     = (hs_cnt_d != '0);
        vs_d     = (vs_cnt_d != '0);
        ha_d     = (hc_d < cfg_d.h_disp);
        va_d     = (state_d == ROWS) && (vc_d < cfg_d.v_disp);
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ROWS;
            cfg_q      <= '0;
            started_q  <= 1'b0;
            pix_q      <= '0;
            hc_q       <= '0;
            ra_q       <= '0;
            vc_q       <= '0;
            row_base_q <= '0;
            hs_cnt_q   <= '0;
            vs_cnt_q   <= '0;
            addr_q     <= '0;
            strobe_q   <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            ha_q       <= 1'b0;
            va_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            started_q  <= 1'b1;
            pix_q      <= pix_d;
            hc_q       <= hc_d;
            ra_q       <= ra_d;
            vc_q       <= vc_d;
            row_base_q <= row_base_d;
            hs_cnt_q   <= hs_cnt_d;
            vs_cnt_q   <= vs_cnt_d;
            addr_q     <= addr_d;
            strobe_q   <= strobe_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            ha_q       <= ha_d;
            va_q       <= va_d;
            fs_q       <= fs_d;
        end
    end

    assign addr_out    = addr_q;
    assign ra_out      = ra_q;
    assign char_strobe = strobe_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign h_active    = ha_q;
    assign v_active    = va_q;
    assign frame_start = fs_q;

`ifdef CRTC_TIMING_CURSOR_EN
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [RA_BITS-1:0]    cur_start_q, cur_start_d;
    logic [RA_BITS-1:0]    cur_end_q, cur_end_d;
    logic                  cur_blink_q, cur_blink_d;
    logic [4:0]            frame_cnt_q, frame_cnt_d;
    logic                  cursor_q, cursor_d;

    always_comb begin
        cur_addr_d  = cur_addr_q;
        cur_start_d = cur_start_q;
        cur_end_d   = cur_end_q;
        cur_blink_d = cur_blink_q;
        frame_cnt_d = frame_cnt_q;
        if (fs_d) begin
            cur_addr_d  = cursor_addr;
            cur_start_d = cursor_start;
            cur_end_d   = cursor_end;
            cur_blink_d = cursor_blink;
            frame_cnt_d = started_q ? frame_cnt_q + 5'd1 : 5'd0;
        end
        // Bit 4 of the frame count gives a 16-on / 16-off blink.
        cursor_d = (addr_d == cur_addr_d) && (ra_d >= cur_start_d) && (ra_d <= cur_end_d)
                   && (state_d == ROWS) && (!cur_blink_d || !frame_cnt_d[4]);
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            cur_addr_q  <= '0;
            cur_start_q <= '0;
            cur_end_q   <= '0;
            cur_blink_q <= 1'b0;
            frame_cnt_q <= '0;
            cursor_q    <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            cur_start_q <= cur_start_d;
            cur_end_q   <= cur_end_d;
            cur_blink_q <= cur_blink_d;
            frame_cnt_q <= frame_cnt_d;
            cursor_q    <= cursor_d;
        end
    end

    assign cursor = cursor_q;
`endif

endmodule
